// File: rtl/lfsr_rng_arb.sv
// Shared Galois-LFSR random word server with a round-robin req/gnt arbiter.
// Build option: define LFSR_RNG_LEAP_EN to apply all STEPS shifts in a single cycle.
module lfsr_rng_arb #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = 32'h8020_0003,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1),
    parameter int                    REQ_NUM    = 4,
    parameter int                    STEPS      = DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  seed_wr_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [REQ_NUM-1:0]    req_i,
    output logic [REQ_NUM-1:0]    gnt_o,
    output logic [DATA_WIDTH-1:0] rnd_o,
    output logic                  busy_o
);

    // state | meaning
    // IDLE  | LFSR holds; arbitrate among requesters unless a seed write is pending
    // SHIFT | LFSR advances toward the next delivered word
    // GRANT | one-hot grant pulse, rnd_o carries the fresh word, pointer moves to winner

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("lfsr_rng_arb: DATA_WIDTH must be at least 2");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_rng_arb: SEED must be nonzero");
    end
    if (REQ_NUM < 1 || REQ_NUM > 16) begin : g_bad_req
        $error("lfsr_rng_arb: REQ_NUM must be in 1..16");
    end
    if (STEPS < 1 || STEPS > 255) begin : g_bad_steps
        $error("lfsr_rng_arb: STEPS must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] lfsr;
    logic [DATA_WIDTH-1:0] lfsr_adv;
    logic [DATA_WIDTH-1:0] seed_load;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;
    logic                  win_found;
    logic                  shift_done;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] q);
        return {q[0], q[DATA_WIDTH-1:1] ^ (POLY[DATA_WIDTH-2:0] & {(DATA_WIDTH-1){q[0]}})};
    endfunction

`ifdef LFSR_RNG_LEAP_EN
    function automatic logic [DATA_WIDTH-1:0] lfsr_leap(input logic [DATA_WIDTH-1:0] q);
        logic [DATA_WIDTH-1:0] r;
        r = q;
        for (int s = 0; s < STEPS; s++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    always_comb begin
        lfsr_adv   = lfsr_leap(lfsr);
        shift_done = 1'b1;
    end
`else
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [CNT_W-1:0] cnt;

    always_comb begin
        lfsr_adv   = lfsr_step(lfsr);
        shift_done = (cnt == CNT_W'(STEPS - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || state != SHIFT || seed_wr_i || shift_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

    // a zero seed would lock the LFSR, so it is replaced by SEED
    assign seed_load = (seed_i == '0) ? SEED : seed_i;

    // highest k first so the nearest requester after the pointer wins last
    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        cand      = '0;
        for (int k = REQ_NUM; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % REQ_NUM);
            if (req_i[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            lfsr   <= SEED;
            ptr    <= IDX_W'(REQ_NUM - 1);
            idx    <= '0;
            gnt_o  <= '0;
            rnd_o  <= '0;
            busy_o <= 1'b0;
        end else begin
            gnt_o <= '0;
            case (state)
                IDLE: begin
                    if (seed_wr_i) begin
                        lfsr <= seed_load;
                    end else if (win_found) begin
                        idx    <= win_idx;
                        state  <= SHIFT;
                        busy_o <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (seed_wr_i) begin
                        lfsr   <= seed_load;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        lfsr <= lfsr_adv;
                        if (shift_done) begin
                            rnd_o <= lfsr_adv;
                            gnt_o <= REQ_NUM'(1) << idx;
                            state <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    ptr    <= idx;
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (seed_wr_i) begin
                        lfsr <= seed_load;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arb.sv
// Scoreboard bench for lfsr_rng_arb: transaction-level reference model feeds
// expected grants to a negedge monitor. Honours LFSR_RNG_LEAP_EN for latency.
module tb_lfsr_rng_arb;

    localparam int W     = 4;
    localparam int N     = 4;
    localparam int STEPS = 2;
    localparam int POLY  = 4'h4;
    localparam int SEED  = 1;
`ifdef LFSR_RNG_LEAP_EN
    localparam int LAT = 1;
`else
    localparam int LAT = STEPS;
`endif

    bit             clk;
    logic           rst;
    logic           seed_wr;
    logic [W-1:0]   seed_v;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [W-1:0]   rnd;
    logic           busy;

    logic [N-1:0]   held;
    bit             end_req;
    bit             done;

    // scoreboard: written by the model (wr_ptr side), read by the monitor (rd_ptr side)
    int exp_idx [64];
    int exp_val [64];
    int exp_cyc [64];
    int wr_ptr;
    int rd_ptr;

    int cyc;
    bit rst_q;
    bit exp_busy;
    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    lfsr_rng_arb #(
        .DATA_WIDTH (W),
        .POLY       (4'h4),
        .SEED       (4'h1),
        .REQ_NUM    (N),
        .STEPS      (STEPS)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .seed_wr_i (seed_wr),
        .seed_i    (seed_v),
        .req_i     (req),
        .gnt_o     (gnt),
        .rnd_o     (rnd),
        .busy_o    (busy)
    );

    // One right shift; a set LSB feeds back into the top bit and every POLY tap.
    function automatic int mstep(input int q);
        int fb;
        fb = (POLY & ((1 << (W - 1)) - 1)) | (1 << (W - 1));
        return ((q & 1) == 1) ? ((q >> 1) ^ fb) : (q >> 1);
    endfunction

    // Reference model: tracks the word sequence and the arbiter at transaction level.
    initial begin : model
        bit pending;
        int gcyc;
        int p_idx;
        int ptr_m;
        int lfsr_m;
        int rq;
        int w;
        int c;
        int sf;
        pending = 0; gcyc = 0; p_idx = 0; ptr_m = N - 1; lfsr_m = SEED;
        forever begin
            @(posedge clk);
            rst_q = rst;
            sf = (int'(seed_v) == 0) ? SEED : int'(seed_v);
            if (rst) begin
                if (pending && cyc != gcyc) wr_ptr--;
                pending = 0;
                lfsr_m  = SEED;
                ptr_m   = N - 1;
            end else if (pending && cyc == gcyc) begin
                ptr_m   = p_idx;
                pending = 0;
                if (seed_wr) lfsr_m = sf;
            end else if (pending) begin
                if (seed_wr) begin
                    wr_ptr--;
                    pending = 0;
                    lfsr_m  = sf;
                end
            end else if (seed_wr) begin
                lfsr_m = sf;
            end else if (req != '0) begin
                rq = int'(req);
                w  = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (ptr_m + k) % N;
                    if (w < 0 && ((rq >> c) & 1) == 1) w = c;
                end
                for (int s = 0; s < STEPS; s++) lfsr_m = mstep(lfsr_m);
                gcyc  = cyc + 1 + LAT;
                p_idx = w;
                exp_idx[wr_ptr[5:0]] = w;
                exp_val[wr_ptr[5:0]] = lfsr_m;
                exp_cyc[wr_ptr[5:0]] = gcyc;
                wr_ptr++;
                pending = 1;
            end
            exp_busy = pending;
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    initial begin : monitor
        int exp_rnd;
        bit due;
        exp_rnd = 0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("reset_gnt", {{(32-N){1'b0}}, gnt}, 0);
                chk("reset_rnd", {{(32-W){1'b0}}, rnd}, 0);
                chk("reset_busy", {31'b0, busy}, 0);
                exp_rnd = 0;
            end else begin
                due = (rd_ptr != wr_ptr) && (exp_cyc[rd_ptr[5:0]] == cyc);
                if (gnt != '0 || due) begin
                    if (rd_ptr == wr_ptr) begin
                        chk("unexpected_gnt", {{(32-N){1'b0}}, gnt}, 0);
                    end else begin
                        chk("gnt", {{(32-N){1'b0}}, gnt}, 32'(1) << exp_idx[rd_ptr[5:0]]);
                        chk("rnd", {{(32-W){1'b0}}, rnd}, exp_val[rd_ptr[5:0]]);
                        chk("gnt_cycle", cyc, exp_cyc[rd_ptr[5:0]]);
                        exp_rnd = exp_val[rd_ptr[5:0]];
                        rd_ptr++;
                    end
                end else begin
                    chk("rnd_hold", {{(32-W){1'b0}}, rnd}, exp_rnd);
                end
                chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            end
            if (end_req && !done) begin
                chk("drained", wr_ptr - rd_ptr, 0);
                done = 1;
            end
        end
    end

    // Drive one cycle of inputs; requesters drop their line once they see their grant.
    task automatic tick(input logic [N-1:0] raise, input logic sw, input logic [W-1:0] sv,
                        input logic r);
        @(negedge clk);
        held    = (held & ~gnt) | raise;
        req     = held;
        seed_wr = sw;
        seed_v  = sv;
        rst     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, '0, 1'b0);
    endtask

    initial begin : stim
        logic [N-1:0] raise;
        logic         sw;
        logic [W-1:0] sv;
        logic         r;
        int           guard;
        rst = 1'b1; seed_wr = 1'b0; seed_v = '0; req = '0; held = '0;

        tick('0, 1'b0, '0, 1'b1);
        tick('0, 1'b0, '0, 1'b1);
        // single requester, then re-request
        tick(4'b0001, 1'b0, '0, 1'b0);
        idle(5);
        tick(4'b0001, 1'b0, '0, 1'b0);
        idle(6);
        // fairness with all lines held
        for (int i = 0; i < 20; i++) tick(4'b1111, 1'b0, '0, 1'b0);
        idle(24);
        // zero seed in IDLE falls back to SEED
        tick('0, 1'b1, 4'h0, 1'b0);
        tick(4'b0001, 1'b0, '0, 1'b0);
        idle(6);
        // seed during SHIFT aborts, same requester wins again
        tick(4'b0100, 1'b0, '0, 1'b0);
        tick('0, 1'b1, 4'h3, 1'b0);
        idle(8);
        // seed on the grant cycle: grant completes, seed applies afterwards
        tick(4'b0010, 1'b0, '0, 1'b0);
        idle(LAT);
        tick('0, 1'b1, 4'h9, 1'b0);
        idle(4);
        tick(4'b1000, 1'b0, '0, 1'b0);
        idle(6);
        // reset during SHIFT
        tick(4'b0001, 1'b0, '0, 1'b0);
        tick('0, 1'b0, '0, 1'b1);
        idle(8);

        for (int i = 0; i < 2500; i++) begin
            raise = '0;
            for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) raise[b] = 1'b1;
            sw = ($urandom_range(24) == 0);
            sv = ($urandom_range(3) == 0) ? '0 : W'($urandom_range(15));
            r  = ($urandom_range(299) == 0);
            tick(raise, sw, sv, r);
        end

        guard = 0;
        while (held != '0 && guard < 300) begin
            idle(1);
            guard++;
        end
        idle(4);
        end_req = 1;
        guard = 0;
        while (!done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            $display("FAIL end_of_test: monitor did not reach final check");
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
